// File: rtl/tx_keep_sequencer.sv
// tx_keep_sequencer: per-frame beat sequencer for the 64-bit AXI-Stream TX path.
// Accepts one byte-length descriptor at a time and forwards exactly ceil(len/8)
// upstream beats. For each beat it generates an MSB-first, left-aligned tkeep
// and a tlast flag from the remaining byte count.
// Optional feature macro: TXSEQ_STAT_EN enables the frame/beat statistics counters.
module tx_keep_sequencer #(
    parameter int LEN_W = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             desc_valid,
    output logic             desc_ready,
    input  logic [LEN_W-1:0] desc_len,
    input  logic [63:0]      s_tdata,
    input  logic             s_tvalid,
    output logic             s_tready,
    output logic [63:0]      m_tdata,
    output logic [7:0]       m_tkeep,
    output logic             m_tlast,
    output logic             m_tvalid,
    input  logic             m_tready,
    output logic             zero_len_err,
    output logic [31:0]      frame_cnt,
    output logic [31:0]      beat_cnt
);

    typedef enum logic {
        ST_IDLE  = 1'b0,
        ST_BURST = 1'b1
    } state_t;

    localparam logic [LEN_W-1:0] BEAT_BYTES = LEN_W'(8);

    // Top n bits set: n=1 -> 8'h80 ... n=8 -> 8'hFF (bit 7 is the first byte).
    function automatic logic [7:0] keep_of(input logic [3:0] n);
        keep_of = ~(8'hFF >> n);
    endfunction

    state_t           r_state;
    logic [LEN_W-1:0] r_rem;
    logic             r_desc_ready;
    logic             r_zero_len_err;
    logic [63:0]      r_m_tdata;
    logic [7:0]       r_m_tkeep;
    logic             r_m_tlast;
    logic             r_m_tvalid;

    logic             w_s_tready;
    logic             w_up;
    logic             w_dn;
    logic             w_rem_gt8;
    logic [3:0]       w_take;
    logic [LEN_W-1:0] w_rem_next;

    // The output register can take a new beat when it is empty or being drained.
    assign w_s_tready = (r_state == ST_BURST) && (!r_m_tvalid || m_tready);
    assign w_up       = s_tvalid && w_s_tready;
    assign w_dn       = r_m_tvalid && m_tready;
    assign w_rem_gt8  = (r_rem > BEAT_BYTES);
    assign w_take     = w_rem_gt8 ? 4'd8 : r_rem[3:0];
    assign w_rem_next = w_rem_gt8 ? (r_rem - BEAT_BYTES) : '0;

    // Sequencer FSM with registered handshake, error pulse and output beat register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state        <= ST_IDLE;
            r_rem          <= '0;
            r_desc_ready   <= 1'b0;
            r_zero_len_err <= 1'b0;
            r_m_tdata      <= '0;
            r_m_tkeep      <= '0;
            r_m_tlast      <= 1'b0;
            r_m_tvalid     <= 1'b0;
        end else begin
            r_zero_len_err <= 1'b0;
            if (w_dn && !w_up) begin
                r_m_tvalid <= 1'b0;
            end
            case (r_state)
                ST_IDLE: begin
                    r_desc_ready <= 1'b1;
                    if (desc_valid && r_desc_ready) begin
                        if (desc_len == '0) begin
                            // Zero-length descriptors are consumed without emitting a beat.
                            r_zero_len_err <= 1'b1;
                        end else begin
                            r_rem        <= desc_len;
                            r_state      <= ST_BURST;
                            r_desc_ready <= 1'b0;
                        end
                    end
                end
                ST_BURST: begin
                    if (w_up) begin
                        r_m_tdata  <= s_tdata;
                        r_m_tkeep  <= keep_of(w_take);
                        r_m_tlast  <= !w_rem_gt8;
                        r_m_tvalid <= 1'b1;
                        r_rem      <= w_rem_next;
                        if (!w_rem_gt8) begin
                            r_state      <= ST_IDLE;
                            r_desc_ready <= 1'b1;
                        end
                    end
                end
                default: begin
                    r_state <= ST_IDLE;
                end
            endcase
        end
    end

    assign desc_ready   = r_desc_ready;
    assign s_tready     = w_s_tready;
    assign zero_len_err = r_zero_len_err;
    assign m_tdata      = r_m_tdata;
    assign m_tkeep      = r_m_tkeep;
    assign m_tlast      = r_m_tlast;
    assign m_tvalid     = r_m_tvalid;

`ifdef TXSEQ_STAT_EN
    logic [31:0] r_frame_cnt;
    logic [31:0] r_beat_cnt;

    // Count downstream beats and completed frames; both wrap naturally.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_frame_cnt <= '0;
            r_beat_cnt  <= '0;
        end else if (w_dn) begin
            r_beat_cnt <= r_beat_cnt + 32'd1;
            if (r_m_tlast) begin
                r_frame_cnt <= r_frame_cnt + 32'd1;
            end
        end
    end

    assign frame_cnt = r_frame_cnt;
    assign beat_cnt  = r_beat_cnt;
`else
    assign frame_cnt = '0;
    assign beat_cnt  = '0;
`endif

endmodule

// File: tb/tb_tx_keep_sequencer.sv
// Scoreboard bench for tx_keep_sequencer: the driver queues expected beats,
// a negedge monitor pops and compares on every downstream handshake.
module tb_tx_keep_sequencer;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        desc_valid;
    logic        desc_ready;
    logic [15:0] desc_len;
    logic [63:0] s_tdata;
    logic        s_tvalid;
    logic        s_tready;
    logic [63:0] m_tdata;
    logic [7:0]  m_tkeep;
    logic        m_tlast;
    logic        m_tvalid;
    logic        m_tready;
    logic        zero_len_err;
    logic [31:0] frame_cnt;
    logic [31:0] beat_cnt;

    tx_keep_sequencer #(.LEN_W(16)) dut (
        .clk(clk), .rst_n(rst_n),
        .desc_valid(desc_valid), .desc_ready(desc_ready), .desc_len(desc_len),
        .s_tdata(s_tdata), .s_tvalid(s_tvalid), .s_tready(s_tready),
        .m_tdata(m_tdata), .m_tkeep(m_tkeep), .m_tlast(m_tlast),
        .m_tvalid(m_tvalid), .m_tready(m_tready),
        .zero_len_err(zero_len_err), .frame_cnt(frame_cnt), .beat_cnt(beat_cnt)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    int hs_first = 0;
    int hs_last = 0;
    int zle_cnt = 0;
    int stall_cycles = 0;
    logic [72:0] exp_q[$];

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    function automatic logic [7:0] exp_keep(input int n);
        case (n)
            1: exp_keep = 8'h80;
            2: exp_keep = 8'hC0;
            3: exp_keep = 8'hE0;
            4: exp_keep = 8'hF0;
            5: exp_keep = 8'hF8;
            6: exp_keep = 8'hFC;
            7: exp_keep = 8'hFE;
            default: exp_keep = 8'hFF;
        endcase
    endfunction

    // Monitor: compare each downstream beat and check stability during stalls.
    logic [72:0] mon_e;
    logic [72:0] held;
    logic        hold_v = 1'b0;
    always @(negedge clk) begin
        if (!rst_n) begin
            hold_v = 1'b0;
        end else begin
            if (zero_len_err) zle_cnt++;
            if (hold_v) begin
                chk("stall_hold", {m_tdata, m_tkeep, m_tlast}, held[63:0] == held[63:0] ? {m_tdata, m_tkeep, m_tlast} : 73'd0);
                chk("stall_data", m_tdata, held[72:9]);
                chk("stall_keep", {56'd0, m_tkeep}, {56'd0, held[8:1]});
                chk("stall_last", {63'd0, m_tlast}, {63'd0, held[0]});
            end
            if (m_tvalid && !m_tready) begin
                stall_cycles++;
                chk("stall_s_tready", {63'd0, s_tready}, 64'd0);
                held   = {m_tdata, m_tkeep, m_tlast};
                hold_v = 1'b1;
            end else begin
                hold_v = 1'b0;
            end
            if (m_tvalid && m_tready) begin
                if (exp_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_beat: got data %h keep %h last %b, expected no beat", m_tdata, m_tkeep, m_tlast);
                end else begin
                    mon_e = exp_q.pop_front();
                    chk("beat_data", m_tdata, mon_e[72:9]);
                    chk("beat_keep", {56'd0, m_tkeep}, {56'd0, mon_e[8:1]});
                    chk("beat_last", {63'd0, m_tlast}, {63'd0, mon_e[0]});
                end
            end
        end
    end

    task automatic send_desc(input logic [15:0] len);
        int t = 0;
        while (!desc_ready && t < 100) begin
            @(posedge clk); #1;
            t++;
        end
        if (!desc_ready) begin
            checks++;
            errors++;
            $display("FAIL desc_ready_timeout: got 0 expected 1");
        end
        desc_valid = 1'b1;
        desc_len   = len;
        @(posedge clk); #1;
        desc_valid = 1'b0;
    endtask

    task automatic send_beats(input int len, input int nb, input logic [63:0] base);
        int rem = len;
        int kb;
        for (int i = 0; i < nb; i++) begin
            kb  = (rem > 8) ? 8 : rem;
            exp_q.push_back({base + 64'(i), exp_keep(kb), (rem <= 8)});
            rem = (rem > 8) ? rem - 8 : 0;
        end
        for (int i = 0; i < nb; i++) begin
            int t = 0;
            logic ok = 1'b0;
            s_tvalid = 1'b1;
            s_tdata  = base + 64'(i);
            while (!ok && t < 200) begin
                @(negedge clk);
                ok = s_tready;
                if (ok) begin
                    if (i == 0) hs_first = cyc;
                    hs_last = cyc;
                end
                @(posedge clk); #1;
                t++;
            end
            if (!ok) begin
                checks++;
                errors++;
                $display("FAIL s_tready_timeout: beat %0d got no accept expected accept", i);
            end
        end
        s_tvalid = 1'b0;
    endtask

    task automatic drain();
        int t = 0;
        while (exp_q.size() != 0 && t < 1000) begin
            @(posedge clk); #1;
            t++;
        end
        repeat (2) @(posedge clk);
        #1;
        chk("queue_empty", 64'(exp_q.size()), 64'd0);
    endtask

    int prev_last;
    logic saw_tv, saw_tr;

    initial begin
        rst_n      = 1'b0;
        desc_valid = 1'b0;
        desc_len   = '0;
        s_tdata    = '0;
        s_tvalid   = 1'b0;
        m_tready   = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_m_tvalid", {63'd0, m_tvalid}, 64'd0);
        chk("rst_m_tlast", {63'd0, m_tlast}, 64'd0);
        chk("rst_m_tdata", m_tdata, 64'd0);
        chk("rst_m_tkeep", {56'd0, m_tkeep}, 64'd0);
        chk("rst_desc_ready", {63'd0, desc_ready}, 64'd0);
        chk("rst_zero_len_err", {63'd0, zero_len_err}, 64'd0);
        chk("rst_frame_cnt", {32'd0, frame_cnt}, 64'd0);
        chk("rst_beat_cnt", {32'd0, beat_cnt}, 64'd0);
        rst_n = 1'b1;
        chk("desc_ready_before_edge", {63'd0, desc_ready}, 64'd0);
        @(posedge clk); #1;
        chk("desc_ready_after_edge", {63'd0, desc_ready}, 64'd1);

        // len 20: FF, FF, F0
        send_desc(16'd20);
        send_beats(20, 3, 64'hA000_0000_0000_0000);
        chk("len20_desc_ready_back", {63'd0, desc_ready}, 64'd1);

        // len 8 then len 1 back-to-back
        send_desc(16'd8);
        send_beats(8, 1, 64'hB000_0000_0000_0000);
        prev_last = hs_last;
        send_desc(16'd1);
        send_beats(1, 1, 64'hC000_0000_0000_0000);
        chk("b2b_gap_cycles", 64'(hs_first - prev_last), 64'd2);

        // zero-length descriptor
        drain();
        zle_cnt = 0;
        saw_tv  = 1'b0;
        saw_tr  = 1'b0;
        send_desc(16'd0);
        repeat (5) begin
            @(negedge clk);
            saw_tv |= m_tvalid;
            saw_tr |= s_tready;
        end
        chk("zero_len_pulse_cycles", 64'(zle_cnt), 64'd1);
        chk("zero_len_m_tvalid", {63'd0, saw_tv}, 64'd0);
        chk("zero_len_s_tready", {63'd0, saw_tr}, 64'd0);
        chk("zero_len_desc_ready", {63'd0, desc_ready}, 64'd1);

        // len 17 with a 3-cycle downstream stall on the first beat
        @(posedge clk); #1;
        m_tready = 1'b0;
        stall_cycles = 0;
        send_desc(16'd17);
        fork
            send_beats(17, 3, 64'hD000_0000_0000_0000);
            begin
                int t = 0;
                while (!m_tvalid && t < 100) begin
                    @(posedge clk); #1;
                    t++;
                end
                repeat (3) @(posedge clk);
                #1;
                m_tready = 1'b1;
            end
        join
        drain();
        chk("stall_cycle_count", 64'(stall_cycles), 64'd3);

        // reset after the 2nd beat of a 40-byte frame
        send_desc(16'd40);
        send_beats(40, 2, 64'hE000_0000_0000_0000);
        repeat (2) @(posedge clk);
        #1;
        chk("pre_reset_queue", 64'(exp_q.size()), 64'd0);
        rst_n = 1'b0;
        #1;
        chk("midrst_m_tvalid", {63'd0, m_tvalid}, 64'd0);
        chk("midrst_m_tlast", {63'd0, m_tlast}, 64'd0);
        chk("midrst_m_tdata", m_tdata, 64'd0);
        chk("midrst_m_tkeep", {56'd0, m_tkeep}, 64'd0);
        chk("midrst_s_tready", {63'd0, s_tready}, 64'd0);
        chk("midrst_desc_ready", {63'd0, desc_ready}, 64'd0);
        chk("midrst_frame_cnt", {32'd0, frame_cnt}, 64'd0);
        chk("midrst_beat_cnt", {32'd0, beat_cnt}, 64'd0);
        exp_q.delete();
        @(posedge clk); #1;
        rst_n = 1'b1;
        send_desc(16'd3);
        send_beats(3, 1, 64'hF000_0000_0000_0003);
        send_desc(16'd20);
        send_beats(20, 3, 64'h1111_0000_0000_0000);
        send_desc(16'd8);
        send_beats(8, 1, 64'h2222_0000_0000_0000);
        send_desc(16'd1);
        send_beats(1, 1, 64'h3333_0000_0000_0000);
        drain();
`ifdef TXSEQ_STAT_EN
        chk("stat_frame_cnt", {32'd0, frame_cnt}, 64'd4);
        chk("stat_beat_cnt", {32'd0, beat_cnt}, 64'd6);
`else
        chk("stat_frame_cnt", {32'd0, frame_cnt}, 64'd0);
        chk("stat_beat_cnt", {32'd0, beat_cnt}, 64'd0);
`endif

        // maximum length: 8191 full beats then keep FE
        send_desc(16'hFFFF);
        send_beats(65535, 8192, 64'h5555_0000_0000_0000);
        drain();
        chk("maxlen_desc_ready", {63'd0, desc_ready}, 64'd1);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
